mem_arbiter: RTL



---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports, read-return path and shared-memory bus of mem_arbiter.
// The master side drives both requesters and returns memory read data; the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          r0_req;
    logic          r0_lock;
    logic          r0_we;
    logic [AW-1:0] r0_adr;
    logic [DW-1:0] r0_wd;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_lock;
    logic          r1_we;
    logic [AW-1:0] r1_adr;
    logic [DW-1:0] r1_wd;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport master (
        output r0_req, r0_lock, r0_we, r0_adr, r0_wd,
        output r1_req, r1_lock, r1_we, r1_adr, r1_wd,
        output mem_rd,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_we, mem_adr, mem_wd
    );

    modport slave (
        input  r0_req, r0_lock, r0_we, r0_adr, r0_wd,
        input  r1_req, r1_lock, r1_we, r1_adr, r1_wd,
        input  mem_rd,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_we, mem_adr, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core (port 0) and the loader/debug master (port 1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build gives port 0 fixed priority.
module mem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned     CNT_W     = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
    } req_t;

    owner_t           owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic    hold0, hold1;
    logic    gnt0, gnt1;
    logic    lock;
    req_t    req0, req1, sel_req;

    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    assign req0 = {bus.r0_we, bus.r0_adr, bus.r0_wd};
    assign req1 = {bus.r1_we, bus.r1_adr, bus.r1_wd};

    // Ownership/tie state register
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decision and next ownership state
    always_comb begin
        owner_d = OWN_NONE;
        last_d  = last_q;
        cnt_d   = '0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        lock    = 1'b0;

        // A live burst keeps its grant only while the owner still requests and the limit is not hit
        hold0 = (owner_q == OWN_P0) && bus.r0_req && (cnt_q < CNT_LIMIT);
        hold1 = (owner_q == OWN_P1) && bus.r1_req && (cnt_q < CNT_LIMIT);

        if (!reset) begin
            if (hold0) begin
                gnt0 = 1'b1;
            end else if (hold1) begin
                gnt1 = 1'b1;
            end else if (bus.r0_req && bus.r1_req) begin
`ifdef MEM_ARB_RR_EN
                gnt0 = last_q;
                gnt1 = !last_q;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = bus.r0_req;
                gnt1 = bus.r1_req;
            end
        end

        if (gnt0 || gnt1) begin
            last_d = gnt1;
            lock   = gnt1 ? bus.r1_lock : bus.r0_lock;
            if (lock && (cnt_q != CNT_LIMIT)) begin
                owner_d = gnt1 ? OWN_P1 : OWN_P0;
                cnt_d   = (hold0 || hold1) ? cnt_q + CNT_W'(1) : CNT_W'(1);
            end
        end
    end

    // Winner's request steers the memory; idle bus is all zeros
    always_comb begin
        sel_req = '0;
        if (gnt0) begin
            sel_req = req0;
        end else if (gnt1) begin
            sel_req = req1;
        end
    end

    // One-cycle registered read return per port
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 && !bus.r0_we;
            rvalid1_q <= gnt1 && !bus.r1_we;
            if (gnt0 && !bus.r0_we) begin
                rdata0_q <= bus.mem_rd;
            end
            if (gnt1 && !bus.r1_we) begin
                rdata1_q <= bus.mem_rd;
            end
        end
    end

    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.mem_we    = sel_req.we;
    assign bus.mem_adr   = sel_req.adr;
    assign bus.mem_wd    = sel_req.wd;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
endmodule
